// File: rtl/pipe_mux_n.sv
// ============================================================================
// Module   : pipe_mux_n
// Purpose  : Pipelined NCH:1 channel multiplexer with a valid strobe, a channel
//            tag and an auto-scan mode. `define PIPE_MUX_STAGE_REG_EN to put a
//            register after every tree level; otherwise the tree is combinational.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_mux_n #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 8,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] inp,
    input  logic [SELW-1:0]      se,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [SELW-1:0]      out_ch
);

    logic [SELW-1:0]      r_scan_ch;
    logic [SELW-1:0]      w_sel;
    logic [NCH*WIDTH-1:0] r_in_data;
    logic [SELW-1:0]      r_in_sel;
    logic                 r_in_vld;

    assign w_sel = mode ? r_scan_ch : se;

    // Manual mode parks the scan counter so the next scan run starts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_ch <= '0;
        end else if (!mode) begin
            r_scan_ch <= '0;
        end else if (in_valid) begin
            r_scan_ch <= r_scan_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_data <= '0;
            r_in_sel  <= '0;
            r_in_vld  <= 1'b0;
        end else begin
            r_in_vld <= in_valid;
            if (in_valid) begin
                r_in_data <= inp;
                r_in_sel  <= w_sel;
            end
        end
    end

    for (genvar l = 0; l < SELW; l++) begin : g_lvl
        localparam int c_nin  = NCH >> l;
        localparam int c_nout = NCH >> (l + 1);

        logic [c_nin*WIDTH-1:0]  w_din;
        logic [SELW-1:0]         w_tin;
        logic                    w_vin;
        logic [c_nout*WIDTH-1:0] w_mux;
        logic [c_nout*WIDTH-1:0] w_dout;
        logic [SELW-1:0]         w_tout;
        logic                    w_vout;

        if (l == 0) begin : g_first
            assign w_din = r_in_data;
            assign w_tin = r_in_sel;
            assign w_vin = r_in_vld;
        end else begin : g_next
            assign w_din = g_lvl[l-1].w_dout;
            assign w_tin = g_lvl[l-1].w_tout;
            assign w_vin = g_lvl[l-1].w_vout;
        end

        // Level l resolves select bit l: pairs (2j, 2j+1) collapse to node j.
        for (genvar j = 0; j < c_nout; j++) begin : g_node
            assign w_mux[j*WIDTH +: WIDTH] = w_tin[l] ? w_din[(2*j+1)*WIDTH +: WIDTH]
                                                      : w_din[(2*j)*WIDTH +: WIDTH];
        end

`ifdef PIPE_MUX_STAGE_REG_EN
        logic [c_nout*WIDTH-1:0] r_data;
        logic [SELW-1:0]         r_tag;
        logic                    r_vld;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data <= '0;
                r_tag  <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= w_vin;
                if (w_vin) begin
                    r_data <= w_mux;
                    r_tag  <= w_tin;
                end
            end
        end

        assign w_dout = r_data;
        assign w_tout = r_tag;
        assign w_vout = r_vld;
`else
        assign w_dout = w_mux;
        assign w_tout = w_tin;
        assign w_vout = w_vin;
`endif
    end

`ifdef PIPE_MUX_STAGE_REG_EN
    assign out       = g_lvl[SELW-1].w_dout;
    assign out_ch    = g_lvl[SELW-1].w_tout;
    assign out_valid = g_lvl[SELW-1].w_vout;
`else
    logic [WIDTH-1:0] r_out;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= g_lvl[SELW-1].w_vout;
            if (g_lvl[SELW-1].w_vout) begin
                r_out    <= g_lvl[SELW-1].w_dout;
                r_out_ch <= g_lvl[SELW-1].w_tout;
            end
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_mux_n.md
# pipe_mux_n

- Parametrised, pipelined N-to-1 multiplexer for WIDTH-bit channels.
- Built as a log2(NCH)-level tree of 2:1 selections. Level 0 uses select bit 0 (LSB); the last level uses the MSB.
- Adds a valid handshake, a channel tag that travels with each data beat, and an auto-scan mode that steps through all channels in order.
- It is the next-generation channel selector in the datapath. It sits between the multi-channel sample buses and single-stream consumers.

## Interface
Parameters:
- WIDTH, 8, bits per channel (≥1)
- NCH, 8, channel count; power of two, ≥2
- SELW (localparam), log2(NCH), select/tag width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- inp  input  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- se  input  SELW  manual channel select; used when mode=0
- mode  input  1  0 = manual select, 1 = auto-scan
- in_valid  input  1  beat accepted on this clk edge when 1
- out  output  WIDTH  selected data
- out_valid  output  1  one-cycle strobe marking a new beat on out
- out_ch  output  SELW  channel index of the beat on out

## Operation
- No backpressure. A beat is accepted on every edge where in_valid=1, which gives full throughput of one beat per cycle.
- Effective select for an accepted beat:
  - mode=0: se.
  - mode=1: internal scan counter scan_ch.
- The beat's data is inp as sampled on its accept edge. inp and se may change freely afterwards.
- scan_ch behaviour:
  - Reset value is 0.
  - Forced to 0 on every edge with mode=0.
  - With mode=1 and in_valid=1, it increments by 1, wrapping NCH-1 → 0.
  - With mode=1 and in_valid=0, it holds.
  - Result: the first scan beat after entering mode=1 is always channel 0.
- Each pipeline stage carries data, the remaining select bits, and a valid bit.
  - The valid bit shifts every cycle.
  - Data and select registers load only when their incoming valid=1. out and out_ch therefore hold the last delivered beat.
- out_ch equals the effective select of the beat; out equals channel out_ch of that beat's sampled inp.
- Reset (asserted at any time, including mid-flight):
  - out=0, out_valid=0, out_ch=0, scan_ch=0.
  - All in-flight beats are discarded. No beat accepted before reset ever emerges.

## Timing
- Latency L, measured from the accept edge to the edge where out_valid=1 and out is valid:
  - L = 1 without the macro.
  - L = SELW with the macro (3 for NCH=8).
- out_valid is high for exactly one cycle per accepted beat.
- Beats emerge in acceptance order with no gaps added or removed.
- The effect of rst is visible on outputs immediately, not clocked. The first acceptance is the first clk edge after rst deasserts.
- mode changes take effect on the same edge: the beat accepted on that edge uses the new mode.

## Configuration
- PIPE_MUX_STAGE_REG_EN
  - Defined: a register stage after every tree level. L = SELW, shortest combinational path, for high-clock builds.
  - Undefined: the whole tree is combinational, followed by a single output register. L = 1.
- Functional output sequence is identical in both builds; only latency differs.

## Test plan
All tests use WIDTH=8, NCH=8, and inp channel k = 0x10+k unless noted. Run in both macro builds.
- Reset: hold rst=1 with random inputs → out=0x00, out_valid=0, out_ch=0 throughout.
- Manual single beat: mode=0, se=5, in_valid=1 for one cycle → after L cycles, out=0x15, out_ch=5, out_valid=1 for one cycle. out stays 0x15 afterwards.
- Manual back-to-back, data changing: se=7,0,3 on consecutive cycles, with inp channel values changed to 0xA0+k on the cycle after each accept → outputs 0x17, 0x10, 0x13 on three consecutive cycles, using the originally sampled data.
- Auto-scan wrap: mode=1, in_valid=1 for 10 cycles → out_ch sequence 0..7,0,1; out sequence 0x10..0x17,0x10,0x11.
- Scan gap and mode exit: mode=1, accept 3 beats, in_valid=0 for 3 cycles, accept 2 beats → out_ch 0,1,2,3,4. Then mode=0 for one cycle, then mode=1 → the next scan beat has out_ch=0.
- Async reset mid-flight (macro defined, L=3): accept beats on ch 2,3, assert rst between edges for one cycle → out_valid drops immediately, no stale beat for 4 cycles after release, and the next scan beat has out_ch=0.
